// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage with PC register and IF/ID pipeline register
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_f,
   input  logic        flush_d,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] InstructionAddress,
   input  logic [31:0] ReadInstruction,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic [31:0] fetch_count
);
   logic [31:0] pc;
   logic [31:0] pcPlus4;
   logic [31:0] pcNext;
   logic        bubble;
   logic        capture;

   assign InstructionAddress = pc;
   assign pcPlus4 = pc + 32'd4;

   // redirect beats stall; a redirect or flush turns the word fetched this cycle into a bubble
   always_comb begin
      pcNext  = redirect_valid ? {redirect_target[31:2], 2'b00} : stall_f ? pc : pcPlus4;
      bubble  = redirect_valid | flush_d;
      capture = ~bubble & ~stall_f;
   end

   // program counter register
   always_ff @(posedge clk) begin
      if (rst) pc <= RESET_PC;
      else     pc <= pcNext;
   end

   // IF/ID register and capture counter
   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         if_id_pc       <= 32'd0;
         if_id_pc_plus4 <= 32'd0;
         if_id_instr    <= NOP_INSTR;
         if_id_valid    <= 1'b0;
      end else if (capture) begin
         if_id_pc       <= pc;
         if_id_pc_plus4 <= pcPlus4;
         if_id_instr    <= ReadInstruction;
         if_id_valid    <= 1'b1;
      end
      if (rst)          fetch_count <= 32'd0;
      else if (capture) fetch_count <= fetch_count + 32'd1;
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage
module tb_fetch_stage;
   typedef struct {
      int          idx;
      logic [31:0] addr, pc, p4, instr, cnt;
      logic        v;
   } exp_t;
   typedef struct {
      int          idx;
      logic [31:0] addr, pc, p4;
   } exp2_t;

   logic        clk = 0;
   logic        rst = 1, stall_f = 0, flush_d = 0, redirect_valid = 0;
   logic [31:0] redirect_target = 0;
   logic [31:0] addrA, instrA, pcA, p4A, iA, cntA;
   logic        vA;
   logic [31:0] addrB, instrB, pcB, p4B, iB, cntB;
   logic        vB;
   exp_t        q[$];
   exp2_t       q2[$];
   int          total = 0, bad = 0, stepNo = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      case (a)
         32'd0:   return 32'h0000_0033;
         32'd4:   return 32'h0010_0093;
         32'd8:   return 32'h0020_0113;
         32'd12:  return 32'h0030_0193;
         default: return 32'hBAD0_0000 | a;
      endcase
   endfunction

   assign instrA = memWord(addrA);
   assign instrB = memWord(addrB);

   fetch_stage dut (
      .clk(clk), .rst(rst), .stall_f(stall_f), .flush_d(flush_d),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .InstructionAddress(addrA), .ReadInstruction(instrA),
      .if_id_pc(pcA), .if_id_pc_plus4(p4A), .if_id_instr(iA),
      .if_id_valid(vA), .fetch_count(cntA)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
      .clk(clk), .rst(rst), .stall_f(stall_f), .flush_d(flush_d),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .InstructionAddress(addrB), .ReadInstruction(instrB),
      .if_id_pc(pcB), .if_id_pc_plus4(p4B), .if_id_instr(iB),
      .if_id_valid(vB), .fetch_count(cntB)
   );

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL step%0d %s actual=%h required=%h", idx, name, act, req);
      end
   endtask

   // monitor: after every edge, compare outputs against the next queued expectation
   always @(posedge clk) begin
      #1;
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         chk("addr",  e.idx, addrA, e.addr);
         chk("pc",    e.idx, pcA,   e.pc);
         chk("pc4",   e.idx, p4A,   e.p4);
         chk("instr", e.idx, iA,    e.instr);
         chk("valid", e.idx, {31'd0, vA}, {31'd0, e.v});
         chk("count", e.idx, cntA,  e.cnt);
      end
      if (q2.size() != 0) begin
         exp2_t e2;
         e2 = q2.pop_front();
         chk("wrap_addr", e2.idx, addrB, e2.addr);
         chk("wrap_pc",   e2.idx, pcB,   e2.pc);
         chk("wrap_pc4",  e2.idx, p4B,   e2.p4);
      end
   end

   task automatic step(input logic r, s, f, rv, input logic [31:0] t,
                       input logic [31:0] ea, ep, e4, ei, input logic ev, input logic [31:0] ec);
      @(negedge clk);
      rst = r; stall_f = s; flush_d = f; redirect_valid = rv; redirect_target = t;
      stepNo++;
      q.push_back('{stepNo, ea, ep, e4, ei, ec, ev});
   endtask

   task automatic expWrap(input logic [31:0] ea, ep, e4);
      q2.push_back('{stepNo, ea, ep, e4});
   endtask

   initial begin
      //    rst s f rv tgt           addr  pc    pc4   instr          v  cnt
      step(1, 0, 0, 0, 0,            0,    0,    0,    32'h0000_0013, 0, 0);
      step(0, 0, 0, 0, 0,            4,    0,    4,    32'h0000_0033, 1, 1);
      step(0, 0, 0, 0, 0,            8,    4,    8,    32'h0010_0093, 1, 2);
      step(0, 1, 0, 0, 0,            8,    4,    8,    32'h0010_0093, 1, 2);
      step(0, 1, 0, 0, 0,            8,    4,    8,    32'h0010_0093, 1, 2);
      step(0, 0, 0, 0, 0,            12,   8,    12,   32'h0020_0113, 1, 3);
      step(0, 0, 0, 1, 32'h6,        4,    0,    0,    32'h0000_0013, 0, 3);
      step(0, 0, 0, 0, 0,            8,    4,    8,    32'h0010_0093, 1, 4);
      step(0, 0, 1, 0, 0,            12,   0,    0,    32'h0000_0013, 0, 4);
      step(0, 1, 1, 0, 0,            12,   0,    0,    32'h0000_0013, 0, 4);
      step(0, 1, 0, 1, 32'hB,        8,    0,    0,    32'h0000_0013, 0, 4);
      step(0, 0, 0, 0, 0,            12,   8,    12,   32'h0020_0113, 1, 5);
      step(0, 0, 0, 0, 0,            16,   12,   16,   32'h0030_0193, 1, 6);
      step(0, 0, 0, 0, 0,            20,   16,   20,   32'hBAD0_0010, 1, 7);
      step(1, 1, 0, 0, 0,            0,    0,    0,    32'h0000_0013, 0, 0);
      step(0, 0, 0, 0, 0,            4,    0,    4,    32'h0000_0033, 1, 1);
      step(0, 0, 0, 0, 0,            8,    4,    8,    32'h0010_0093, 1, 2);
      step(0, 0, 0, 0, 0,            12,   8,    12,   32'h0020_0113, 1, 3);
      step(1, 0, 1, 1, 32'h40,       0,    0,    0,    32'h0000_0013, 0, 0);
      expWrap(32'hFFFF_FFFC, 0, 0);
      step(0, 0, 0, 0, 0,            4,    0,    4,    32'h0000_0033, 1, 1);
      expWrap(32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000);
      step(0, 0, 0, 0, 0,            8,    4,    8,    32'h0010_0093, 1, 2);
      for (int i = 0; i < 10 && (q.size() != 0 || q2.size() != 0); i++) @(posedge clk);
      #2;
      if (q.size() != 0 || q2.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain actual=%0d required=0", q.size() + q2.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
